// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Two-requester memory bus bundle: request side, grant/read-return
//           side and the single shared memory port.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int SIZE_W = 2
);

  logic              p0_req;
  logic              p0_we;
  logic [DATA_W-1:0] p0_addr;
  logic [SIZE_W-1:0] p0_size;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [DATA_W-1:0] p1_addr;
  logic [SIZE_W-1:0] p1_size;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [DATA_W-1:0] mem_addr;
  logic [SIZE_W-1:0] mem_size;
  logic              mem_rden;
  logic              mem_wren;
  logic [DATA_W-1:0] memwrite_data;
  logic [DATA_W-1:0] memread_data;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_size, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_size, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_size, mem_rden, mem_wren, memwrite_data,
    input  memread_data
  );

  // Requesters plus memory side
  modport master (
    output p0_req, p0_we, p0_addr, p0_size, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_size, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_size, mem_rden, mem_wren, memwrite_data,
    output memread_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-port arbiter onto a single memory port, one access per cycle,
//           read data returned one cycle after the grant. Define
//           MEM_ARB_RR_EN for round-robin; default is fixed priority to port 0
//           with a HOLD_MAX starvation limit for port 1.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   gnt0, gnt1;
  logic   rvalid0_q, rvalid0_d;
  logic   rvalid1_q, rvalid1_d;

`ifdef MEM_ARB_RR_EN

  // Under contention the port that did not win last cycle goes next.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req && bus.p1_req) begin
        if (state_q == G0) gnt1 = 1'b1;
        else               gnt0 = 1'b1;
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

`else

  localparam int              CNT_W      = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req && bus.p1_req) begin
        if (hold_cnt_q >= HOLD_LIMIT) gnt1 = 1'b1;
        else                          gnt0 = 1'b1;
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  // Counts contended port-0 wins in an unbroken run of port-0 grants.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!bus.p0_req || gnt1) begin
      hold_cnt_d = '0;
    end else if (gnt0 && bus.p1_req) begin
      if (state_q != G0)               hold_cnt_d = CNT_W'(1);
      else if (hold_cnt_q != HOLD_LIMIT) hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end

`endif

  always_comb begin
    state_d   = IDLE;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    if (gnt0) begin
      state_d   = G0;
      rvalid0_d = !bus.p0_we;
    end else if (gnt1) begin
      state_d   = G1;
      rvalid1_d = !bus.p1_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    bus.mem_addr      = '0;
    bus.mem_size      = '0;
    bus.mem_rden      = 1'b0;
    bus.mem_wren      = 1'b0;
    bus.memwrite_data = '0;
    if (gnt0) begin
      bus.mem_addr      = bus.p0_addr;
      bus.mem_size      = bus.p0_size;
      bus.mem_rden      = !bus.p0_we;
      bus.mem_wren      = bus.p0_we;
      bus.memwrite_data = bus.p0_wdata;
    end else if (gnt1) begin
      bus.mem_addr      = bus.p1_addr;
      bus.mem_size      = bus.p1_size;
      bus.mem_rden      = !bus.p1_we;
      bus.mem_wren      = bus.p1_we;
      bus.memwrite_data = bus.p1_wdata;
    end
  end

  // A return still in flight when rst rises is masked here, then dropped.
  always_comb begin
    bus.p0_gnt    = gnt0;
    bus.p1_gnt    = gnt1;
    bus.p0_rvalid = rvalid0_q && !rst;
    bus.p1_rvalid = rvalid1_q && !rst;
    bus.p0_rdata  = bus.p0_rvalid ? bus.memread_data : '0;
    bus.p1_rdata  = bus.p1_rvalid ? bus.memread_data : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed scoreboard bench for mem_arbiter; expected grants and
//           read returns are queued by the stimulus and popped by a monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if #(.DATA_W(32), .SIZE_W(2)) bus ();

  mem_arbiter #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Kinds: 0 = port-0 grant, 1 = port-1 grant, 2 = port-0 rvalid, 3 = port-1 rvalid
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  bit   expect_busy = 1'b0;

  exp_t pend;
  bit   pend_v = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  always @(posedge clk)
    bus.memread_data <= bus.mem_rden ? mem_val(bus.mem_addr) : 32'h0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic match(input logic [1:0] kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL unexpected_event: got kind %0d, want none (t=%0t)", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 160'(kind), 160'(e.kind));
      if (kind < 2'd2) begin
        check("mem_addr", 160'(bus.mem_addr), 160'(e.addr));
        check("mem_rden_wren", 160'({bus.mem_rden, bus.mem_wren}), 160'({!e.we, e.we}));
        check("memwrite_data", 160'(bus.memwrite_data), 160'(e.data));
        check("mem_size", 160'(bus.mem_size), 160'(2'd2));
      end else begin
        check("rdata", 160'((kind == 2'd2) ? bus.p0_rdata : bus.p1_rdata), 160'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs",
            160'({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid,
                  bus.p0_rdata, bus.p1_rdata, bus.mem_rden, bus.mem_wren}), 160'(0));
    end else begin
      check("quiet_outputs",
            160'({bus.p0_rvalid ? 32'h0 : bus.p0_rdata,
                  bus.p1_rvalid ? 32'h0 : bus.p1_rdata,
                  (bus.p0_gnt || bus.p1_gnt) ? 67'h0 :
                    {bus.mem_addr, bus.memwrite_data, bus.mem_size, bus.mem_rden},
                  bus.mem_rden && bus.mem_wren}), 160'(0));
      if (expect_busy) check("busy_cycle", 160'(bus.p0_gnt || bus.p1_gnt), 160'(1));
      if (bus.p0_gnt)    match(2'd0);
      if (bus.p1_gnt)    match(2'd1);
      if (bus.p0_rvalid) match(2'd2);
      if (bus.p1_rvalid) match(2'd3);
    end
  end

  // One cycle of stimulus; g is the hand-computed winner (-1 = none) and
  // rd the data its read must return next cycle.
  task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input int g, input logic [31:0] rd);
    exp_t e;
    rst          = 1'b0;
    bus.p0_req   = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req   = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
    if (g == 0) begin
      e = '{kind: 2'd0, addr: a0, we: w0, data: d0};
      exp_q.push_back(e);
    end else if (g == 1) begin
      e = '{kind: 2'd1, addr: a1, we: w1, data: d1};
      exp_q.push_back(e);
    end
    if (pend_v) exp_q.push_back(pend);
    pend_v = (g == 0) ? !w0 : (g == 1) ? !w1 : 1'b0;
    pend   = '{kind: (g == 1) ? 2'd3 : 2'd2, addr: 32'h0, we: 1'b0, data: rd};
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 32'h0);
  endtask

  task automatic reset_cycles(input int n);
    rst        = 1'b1;
    pend_v     = 1'b0;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef MEM_ARB_RR_EN
  int pat[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
  int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

  initial begin
    logic [31:0] a0;
    logic [31:0] d0;
    rst = 1'b1;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 32'h100; bus.p0_size = 2'd2; bus.p0_wdata = 32'h0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h20;  bus.p1_size = 2'd2; bus.p1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;

    // Lone read of 0x100, granted on the first cycle out of reset
    cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'hDEADBEEF);
    idle_cyc();

    // Continuous contention
    a0 = 32'h1000;
    d0 = 32'h0;
    expect_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, a0, d0, 1'b1, 1'b1, 32'h2000, 32'h11, pat[i], 32'h0);
      if (pat[i] == 0) begin
        a0 = a0 + 32'h4;
        d0 = d0 + 32'h1;
      end
    end
    expect_busy = 1'b0;
    idle_cyc();

    // Port-1 write, no read return
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55, 1, 32'h0);
    idle_cyc();

    // Reset arriving while a port-0 read return is in flight
    cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'hA5A50040);
    reset_cycles(2);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 1, 32'hA5A50104);
    idle_cyc();

    // Back-to-back reads from different ports
    cyc(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'hA5A50200);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 1, 32'hA5A50300);
    idle_cyc();
    idle_cyc();
    idle_cyc();

    check("queue_drained", 160'(exp_q.size()), 160'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4: maximum consecutive grants to one port while the other port is requesting (fixed-priority mode only).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have, for each port p in {0,1}, p_req input 1: access request, held until granted.
REQ-005 SHALL have p_we input 1: 1 = write, 0 = read.
REQ-006 SHALL have p_addr input word_t and p_size input mem_addr_t: byte address and access size.
REQ-007 SHALL have p_wdata input word_t: write data.
REQ-008 SHALL have p_gnt output 1: access issued to memory this cycle.
REQ-009 SHALL have p_rvalid output 1 and p_rdata output word_t: read data return.
REQ-010 SHALL have mem_addr output word_t, mem_size output mem_addr_t, mem_rden output 1, mem_wren output 1, memwrite_data output word_t, and memread_data input word_t (valid one cycle after mem_rden).

Function
REQ-011 SHALL issue at most one memory access per cycle; mem_rden and mem_wren SHALL never both be 1.
REQ-012 SHALL derive p_gnt combinationally in the request cycle; mem_* SHALL carry the granted port's addr/size/wdata/we in that same cycle.
REQ-013 SHALL drive mem_rden = mem_wren = 0 and mem_addr/mem_size/memwrite_data = 0 when no port is granted.
REQ-014 SHALL have a requester keep req, we, addr, size and wdata stable from assertion until the cycle p_gnt=1; it may deassert or issue a new request in the following cycle.
REQ-015 SHALL register a granted read, then assert p_rvalid for exactly one cycle, one cycle after p_gnt, with p_rdata = memread_data; p_rdata SHALL be 0 when p_rvalid=0.
REQ-016 SHALL never assert p_rvalid for writes.
REQ-017 SHALL support back-to-back grants every cycle, so read latency is 1 and throughput is 1 access per cycle.
REQ-018 SHALL, with one port requesting, grant that port in the same cycle.
REQ-019 SHALL, in fixed-priority mode under contention, grant port 0, except that after HOLD_MAX consecutive port-0 grants with port 1 requesting it SHALL grant port 1 for one access.
REQ-020 SHALL clear the hold counter on any port-1 grant and on any cycle with 0_req=0; the counter SHALL saturate and never wrap.
REQ-021 SHALL keep an FSM with states IDLE (no grant last cycle), G0 and G1 (last grant port 0 or port 1); the next state is the port granted this cycle, or IDLE if no grant.

Reset
REQ-022 SHALL, while rst=1, force p_gnt=0, p_rvalid=0, p_rdata=0, mem_rden=0, mem_wren=0, the FSM to IDLE and the hold counter to 0.
REQ-023 SHALL discard a read return pending when rst asserts, so no p_rvalid appears after reset.
REQ-024 SHALL allow grants from the first cycle with rst=0.

Configuration
REQ-025 SHALL, with MEM_ARB_RR_EN defined, use round-robin arbitration: under contention the port not granted most recently wins, and from IDLE port 0 wins; HOLD_MAX is ignored and the hold counter is not built.
REQ-026 SHALL, without MEM_ARB_RR_EN, use fixed-priority arbitration with the HOLD_MAX starvation limit per REQ-019.

Verification
REQ-027 SHALL pass: port 0 reads 0x100 alone, memory returns 0xDEADBEEF -> 0_gnt=1 in cycle N, mem_rden=1 with mem_addr=0x100, then 0_rvalid=1 and 0_rdata=0xDEADBEEF in cycle N+1.
REQ-028 SHALL pass: both ports request continuously, fixed priority, HOLD_MAX=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1.
REQ-029 SHALL pass: same stimulus with MEM_ARB_RR_EN -> grant pattern 0,1,0,1; no cycle without a grant.
REQ-030 SHALL pass: port 1 writes 0x55 to 0x20 while port 0 is idle -> mem_wren=1, memwrite_data=0x55, 1_gnt=1, and no 1_rvalid.
REQ-031 SHALL pass: rst asserted in the cycle after a port-0 read grant -> 0_rvalid stays 0, and all outputs are 0 during reset.
REQ-032 SHALL pass: port 0 read followed by port 1 read in consecutive cycles -> 0_rvalid in N+1 and 1_rvalid in N+2, each carrying its own data.
